// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts a parallel word over a valid/ready handshake
// and streams it out one bit per bit_en strobe, back-to-back when a new
// word is offered as the last bit of the current one is consumed.
module serial_word_feeder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             bit_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    next_idx;
  logic             last;
  logic             consume_last;
  logic             transfer;

  // Maps a serialisation index onto the bit position of the held word.
  function automatic logic [IW-1:0] bit_pos(input logic [IW-1:0] i);
    return (MSB_FIRST != 0) ? (LAST_IDX - i) : i;
  endfunction

  // Handshake and end-of-word decode; ready is combinational on bit_en so
  // the next word can be taken on the very edge that consumes the last bit.
  always_comb begin
    last         = (idx == LAST_IDX);
    next_idx     = idx + 1'b1;
    consume_last = (state == SHIFT) && last && bit_en;
    data_ready   = !reset && ((state == IDLE) || consume_last);
    word_done    = !reset && consume_last;
    transfer     = data_valid && data_ready;
  end

  // Two-state feeder FSM with registered serial outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      word         <= '0;
      serial_out   <= IDLE_LEVEL;
      serial_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            state        <= SHIFT;
            word         <= data_in;
            idx          <= '0;
            serial_out   <= data_in[bit_pos('0)];
            serial_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            if (last) begin
              if (transfer) begin
                word         <= data_in;
                idx          <= '0;
                serial_out   <= data_in[bit_pos('0)];
                serial_valid <= 1'b1;
              end else begin
                state        <= IDLE;
                idx          <= '0;
                serial_out   <= IDLE_LEVEL;
                serial_valid <= 1'b0;
              end
            end else begin
              idx        <= next_idx;
              serial_out <= word[bit_pos(next_idx)];
            end
          end
        end
        default: begin
          state        <= IDLE;
          idx          <= '0;
          serial_out   <= IDLE_LEVEL;
          serial_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Testbench for serial_word_feeder: directed steps with a bit-level
// scoreboard that predicts every serial bit, word_done and data_ready.
module tb_serial_word_feeder;

  localparam int unsigned W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         bit_en;
  logic         serial_out;
  logic         serial_valid;
  logic         word_done;

  logic [W-1:0] data_in_l;
  logic         data_valid_l;
  logic         data_ready_l;
  logic         serial_out_l;
  logic         serial_valid_l;
  logic         word_done_l;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;
  exp_t q[$];

  always #5 clock = ~clock;

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .bit_en(bit_en), .serial_out(serial_out),
    .serial_valid(serial_valid), .word_done(word_done)
  );

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .data_in(data_in_l), .data_valid(data_valid_l),
    .data_ready(data_ready_l), .bit_en(bit_en), .serial_out(serial_out_l),
    .serial_valid(serial_valid_l), .word_done(word_done_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: predicts outputs from the queued bits, then pops consumed
  // bits and pushes the word of any handshake the model says is accepted.
  always @(negedge clock) begin
    logic ev, eo, cons, edone, erdy;
    if (mon_en) begin
      ev    = (q.size() > 0);
      eo    = ev ? q[0].b : 1'b0;
      cons  = !reset && ev && bit_en;
      edone = cons && q[0].last;
      erdy  = !reset && (!ev || edone);
      check("sb_serial_valid", serial_valid, ev);
      check("sb_serial_out", serial_out, eo);
      check("sb_word_done", word_done, edone);
      check("sb_data_ready", data_ready, erdy);
      if (reset) begin
        q.delete();
      end else begin
        if (cons) void'(q.pop_front());
        if (data_valid && erdy) begin
          for (int i = W - 1; i >= 0; i--) begin
            exp_t e;
            e.b    = data_in[i];
            e.last = (i == 0);
            q.push_back(e);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0]   stream;
    logic [W-1:0] e30;
    reset = 1'b1; data_valid = 1'b0; data_in = '0; bit_en = 1'b1;
    data_valid_l = 1'b0; data_in_l = '0;

    // Reset state
    cyc(); cyc();
    check("rst_serial_valid", serial_valid, 0);
    check("rst_serial_out", serial_out, 0);
    check("rst_word_done", word_done, 0);
    check("rst_data_ready", data_ready, 0);
    mon_en = 1'b1;
    reset = 1'b0; #1;
    check("ready_after_rst", data_ready, 1);

    // Single word 1010, MSB first
    e30 = 4'b1010;
    data_in = 4'b1010; data_valid = 1'b1; cyc(); data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("w1010_out", serial_out, e30[3 - i]);
      check("w1010_valid", serial_valid, 1);
      check("w1010_done", word_done, (i == 3));
      check("w1010_ready", data_ready, (i == 3));
      cyc();
    end
    check("w1010_idle_valid", serial_valid, 0);
    check("w1010_idle_out", serial_out, 0);

    // Back-to-back 0101 then 1010 with data_valid held
    data_in = 4'b0101; data_valid = 1'b1; cyc(); data_in = 4'b1010;
    stream = '0;
    for (int i = 0; i < 8; i++) begin
      stream = {stream[6:0], serial_out};
      check("b2b_valid", serial_valid, 1);
      check("b2b_done", word_done, (i == 3 || i == 7));
      cyc();
      if (i == 3) data_valid = 1'b0;
    end
    check("b2b_stream", stream, 8'b0101_1010);
    check("b2b_idle_valid", serial_valid, 0);

    // Stalls: bit_en 0,1,0,1,... during word 1100
    data_in = 4'b1100; data_valid = 1'b1; bit_en = 1'b1; cyc(); data_valid = 1'b0;
    stream = '0;
    for (int i = 0; i < 8; i++) begin
      bit_en = (i % 2 == 1); #1;
      stream = {stream[6:0], serial_out};
      check("stall_done", word_done, (i == 7));
      cyc();
    end
    bit_en = 1'b1;
    check("stall_stream", stream, 8'b1111_0000);
    check("stall_idle_valid", serial_valid, 0);

    // data_in churns while mid-word; only the ready-edge value is captured
    data_in = 4'b0110; data_valid = 1'b1; cyc();
    stream = '0;
    for (int i = 0; i < 4; i++) begin
      stream = {stream[6:0], serial_out};
      data_in = W'($urandom);
      cyc();
    end
    data_valid = 1'b0;
    check("churn_first_word", stream[3:0], 4'b0110);
    repeat (5) cyc();

    // Reset mid-word after two bits of 1011
    data_in = 4'b1011; data_valid = 1'b1; cyc(); data_valid = 1'b0;
    cyc(); cyc();
    reset = 1'b1; #1;
    check("midrst_done", word_done, 0);
    check("midrst_ready", data_ready, 0);
    cyc(); reset = 1'b0; #1;
    check("postrst_valid", serial_valid, 0);
    check("postrst_out", serial_out, 0);
    check("postrst_done", word_done, 0);
    check("postrst_ready", data_ready, 1);
    data_in = 4'b0110; data_valid = 1'b1; cyc(); data_valid = 1'b0;
    repeat (5) cyc();

    // LSB-first instance, word 0001
    data_in_l = 4'b0001; data_valid_l = 1'b1; cyc(); data_valid_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("lsb_out", serial_out_l, (i == 0));
      check("lsb_valid", serial_valid_l, 1);
      check("lsb_done", word_done_l, (i == 3));
      cyc();
    end
    check("lsb_idle_out", serial_out_l, 0);
    check("lsb_idle_valid", serial_valid_l, 0);

    repeat (2) cyc();
    check("sb_drained", q.size(), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
